// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned NumLanes = 4;

  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enable merge; the read port shows the word as it will look after
// the write, so a store's response can report the merged value in the same cycle.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 64,
  parameter int unsigned IdxW  = idx_width(Depth)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IdxW-1:0]     index_i,
  input  logic [31:0]         wdata_i,
  input  logic [NumLanes-1:0] be_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem_q [Depth];

  always_comb begin
    rdata_o = mem_q[index_i];
    if (we_i) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (be_i[i]) rdata_o[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[index_i] <= rdata_o;
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target: one outstanding request, fixed latency, valid/ready response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DepthWords = 64,
  parameter int unsigned Latency    = 2,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  input  logic [NumLanes-1:0] req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam int unsigned IdxW      = idx_width(DepthWords);
  localparam logic [31:0] SizeBytes = 32'(DepthWords * 4);
  localparam logic [31:0] CntInit   = (Latency > 1) ? 32'(Latency - 2) : 32'd0;

  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic                we_q;
  logic [31:0]         addr_q, wdata_q;
  logic [NumLanes-1:0] be_q;

  logic                commit;
  logic                c_we, c_err;
  logic [31:0]         c_addr, c_wdata, offset, arr_rdata;
  logic [NumLanes-1:0] c_be;

  // With single-cycle latency the commit happens in the accept cycle, straight from the inputs.
  always_comb begin
    if (state_q == StIdle) begin
      c_we = req_we_i; c_addr = req_addr_i; c_wdata = req_wdata_i; c_be = req_be_i;
    end else begin
      c_we = we_q; c_addr = addr_q; c_wdata = wdata_q; c_be = be_q;
    end
    offset = c_addr - BaseAddr;
    c_err  = (c_addr[1:0] != 2'b00) || (offset >= SizeBytes);
  end

  dmem_array #(
    .Depth(DepthWords),
    .IdxW (IdxW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (commit & c_we & ~c_err),
    .index_i(offset[IdxW+1:2]),
    .wdata_i(c_wdata),
    .be_i   (c_be),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (Latency == 1) begin
            commit  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 32'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      rdata_d = c_err ? 32'd0 : arr_rdata;
      err_d   = c_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == StIdle && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign busy_o      = (state_q != StIdle);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench over three builds (latency 2, 3 and 1) with a response scoreboard.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int   lat [3] = '{2, 3, 1};
  exp_t sb [$];
  int   vectors = 0;
  int   miscompares = 0;

  dmem_responder #(.DepthWords(64), .Latency(2), .BaseAddr(32'h0000_0000)) u_dut_l2 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_be_i(req_be[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0])
  );

  dmem_responder #(.DepthWords(64), .Latency(3), .BaseAddr(32'h0000_0000)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_be_i(req_be[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1])
  );

  dmem_responder #(.DepthWords(16), .Latency(1), .BaseAddr(32'h4000_0000)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_we_i(req_we[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .req_be_i(req_be[2]), .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
    .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]), .busy_o(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
  endtask

  // Issue one request from an idle cycle (called #1 after a rising edge) and retire it.
  // hold > 0 keeps rsp_ready low that many cycles while a stray store to word 0 is offered.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] er, input logic ee, input int hold);
    int   cyc;
    exp_t e;
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
    sb.push_back('{ee, er});
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = $urandom; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    cyc = 1;
    while (!rsp_valid[d] && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat[d]));
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      e = '{1'b0, 32'd0};
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_rdata", rsp_rdata[d], e.rdata);
    chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    chk("busy_resp", 32'(busy[d]), 32'd1);
    chk("req_ready_resp", 32'(req_ready[d]), 32'd0);
    for (int k = 0; k < hold; k++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h0;
      req_wdata[d] = 32'hBAD0_BAD0; req_be[d] = 4'hF;
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata[d], e.rdata);
      chk("bp_busy", 32'(busy[d]), 32'd1);
      chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    chk("post_rdata_hold", rsp_rdata[d], e.rdata);
    chk("post_rsp_err", 32'(rsp_err[d]), 32'd0);
    chk("post_busy", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    #10;
    for (int d = 0; d < 3; d++) chk_reset(d);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;

    // Latency-2 build: full/partial stores, loads, errors, backpressure.
    do_req(0, 1'b1, 32'h0,   32'hA5A5_0001, 4'hF, 32'hA5A5_0001, 1'b0, 0);
    do_req(0, 1'b1, 32'h8,   32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
    do_req(0, 1'b0, 32'h8,   32'hFFFF_FFFF, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h8,   32'h0000_1200, 4'b0010, 32'hDEAD_12EF, 1'b0, 0);
    do_req(0, 1'b0, 32'h8,   32'h0,         4'h0, 32'hDEAD_12EF, 1'b0, 0);
    do_req(0, 1'b0, 32'h102, 32'h0,         4'hF, 32'h0,         1'b1, 0);
    do_req(0, 1'b1, 32'h100, 32'h1111_1111, 4'hF, 32'h0,         1'b1, 0);
    do_req(0, 1'b0, 32'h0,   32'h0,         4'h0, 32'hA5A5_0001, 1'b0, 0);
    do_req(0, 1'b1, 32'h8,   32'h0,         4'h0, 32'hDEAD_12EF, 1'b0, 0);
    do_req(0, 1'b1, 32'hFC,  32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, 1'b0, 0);
    do_req(0, 1'b0, 32'hFC,  32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, 5);
    @(posedge clk); #1;
    chk("no_stray_accept", 32'(busy[0]), 32'd0);
    do_req(0, 1'b0, 32'h0,   32'h0,         4'h0, 32'hA5A5_0001, 1'b0, 0);

    // Latency-3 build: reset during an outstanding store discards it.
    do_req(1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1'b0, 0);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10;
    req_wdata[1] = 32'h1234_5678; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("l3_busy_before_rst", 32'(busy[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset(1);
    #2;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    chk_reset(1);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Latency-1 build with non-zero base: below-base wrap, then back-to-back loads.
    do_req(2, 1'b1, 32'h4000_0000, 32'h0000_0AAA, 4'hF, 32'h0000_0AAA, 1'b0, 0);
    do_req(2, 1'b1, 32'h4000_0004, 32'h0000_0BBB, 4'hF, 32'h0000_0BBB, 1'b0, 0);
    do_req(2, 1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 0);
    do_req(2, 1'b0, 32'h4000_0040, 32'h0,         4'h0, 32'h0,         1'b1, 0);
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h4000_0000;
    sb.push_back('{1'b0, 32'h0000_0AAA});
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("b2b_rsp_valid", 32'(rsp_valid[2]), 32'(i % 2));
      chk("b2b_req_ready", 32'(req_ready[2]), 32'((i + 1) % 2));
      if (rsp_valid[2] && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("b2b_rdata", rsp_rdata[2], e.rdata);
      end
      if (i % 2 == 0) begin
        if (i < 6) begin
          req_addr[2] = (i % 4 == 2) ? 32'h4000_0004 : 32'h4000_0000;
          sb.push_back('{1'b0, (i % 4 == 2) ? 32'h0000_0BBB : 32'h0000_0AAA});
        end else begin
          req_valid[2] = 1'b0;
        end
      end
    end
    rsp_ready[2] = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
- Accepts one request at a time: address, write data, byte enables, write flag.
- Serves the request from an internal word array after a fixed latency and returns read data through a valid/ready response.
- `busy` feeds the hazard logic so the pipeline can stall the MEM stage during outstanding accesses.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; must be a power of two, at least 4.
- LATENCY, 2, cycles from request acceptance to rsp_valid; must be at least 1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, byte lanes aligned to word.
- req_be  input  4  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  word read, reflecting any write performed by this request.
- rsp_err  output  1  request was out of range or misaligned.
- busy  output  1  a request is accepted and its response is not yet consumed.

Behaviour:
- **Reset** (reset low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0. Array contents are not cleared. A write whose commit edge has not yet occurred when reset asserts is discarded.
- **States:** IDLE, WAIT, RESP. Only one request is outstanding at any time.
- **IDLE:**
  - req_ready=1, busy=0, rsp_valid=0.
  - On req_valid=1 in cycle N, latch req_we/addr/wdata/be.
  - LATENCY=1: commit the access at the end of cycle N, then go to RESP.
  - Otherwise: load counter with LATENCY-2 and go to WAIT.
- **WAIT:**
  - req_ready=0, busy=1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, commit the access at the cycle end, then go to RESP.
- **Commit:**
  - offset = addr - BASE_ADDR.
  - Error if addr[1:0] != 0, or if offset >= DEPTH_WORDS*4.
  - No error:
    - index = offset[log2(DEPTH_WORDS)+1:2].
    - On a store, write enabled bytes only.
    - rsp_rdata = resulting word.
    - req_be=0 on a store changes nothing and is not an error.
  - Error: no write, rsp_rdata=0, rsp_err=1.
- **RESP:**
  - rsp_valid=1 first appears in cycle N+LATENCY. busy=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, return to IDLE: rsp_valid=0, rsp_err=0, and rsp_rdata holds its last value.
  - A new request can be accepted in the cycle after the handshake, never in the same cycle.
- **Loads:** req_wdata and req_be are ignored. Loads always return the full word.
- **Request inputs:** ignored whenever req_ready=0; stability is not required outside acceptance.
- **Arithmetic:** offset uses 32-bit unsigned subtraction. An address below BASE_ADDR wraps to a large offset and is reported as an error.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - function computing the index width from DEPTH_WORDS;
  - constant for the byte-lane count (4).
- Sub-module dmem_array holds the storage and the byte-enable merge:
  - ports: clk, we, index, wdata, be, rdata;
  - synchronous write, combinational read of the merged word.
- The FSM, decode and counter live in dmem_responder.

Test Plan:
- LATENCY=2: store addr 0x8, wdata 0xDEADBEEF, be 4'b1111 in cycle 0 -> rsp_valid in cycle 2, rsp_err=0, rsp_rdata=0xDEADBEEF. Then a load of 0x8 returns 0xDEADBEEF.
- Partial store: after the above, store addr 0x8, wdata 0x00001200, be 4'b0010 -> rsp_rdata=0xDEAD12EF. Then a load confirms 0xDEAD12EF.
- Errors:
  - load addr 0x102 -> rsp_err=1, rsp_rdata=0;
  - store addr DEPTH_WORDS*4 -> rsp_err=1, and a load of word 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and busy remain stable with req_ready=0. A req_valid during this window is not accepted. Raising rsp_ready gives one handshake, and req_ready=1 the next cycle.
- Reset mid-operation: accept a store to 0x10 with data 0x12345678, assert reset in cycle 1 (before commit, LATENCY=3) -> outputs return to reset values immediately. A later load of 0x10 shows the old contents.
- LATENCY=1 build: back-to-back loads with rsp_ready tied to 1 -> one response every 2 cycles, each arriving in the cycle after acceptance.
